// File: rtl/fs_dstack_pkg.sv
// Shared types for the ForthSuper data stack: stack command encoding, the
// stack sequencer states and the core-opcode to stack-command translation.
package fs_dstack_pkg;

    // Stack commands issued by the opcode sequencer and the ALU.
    typedef enum logic [3:0] {
        SS_NOP      = 4'd0,
        SS_PUSH     = 4'd1,
        SS_POP      = 4'd2,
        SS_LOAD     = 4'd3,
        SS_POP_LOAD = 4'd4,
        SS_DUP      = 4'd5,
        SS_DROP     = 4'd6,
        SS_OVER     = 4'd7,
        SS_SWAP     = 4'd8,
        SS_ROT      = 4'd9,
        SS_PICK     = 4'd10
    } ss_op_e;

    // S_RD is the cycle in which a RAM read issued on accept is consumed.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RD   = 1'b1
    } ss_state_e;

    // Core opcodes that reach the stack block (stack class plus neighbours).
    typedef enum logic [5:0] {
        _NOP  = 6'd0,
        _DUP  = 6'd1,
        _DROP = 6'd2,
        _OVER = 6'd3,
        _SWAP = 6'd4,
        _ROT  = 6'd5,
        _PICK = 6'd6,
        _ADD  = 6'd7,
        _SUB  = 6'd8
    } opcode_e;

    // Map a stack-class core opcode to its stack command; anything else is a NOP here.
    function automatic ss_op_e to_ss_op(input opcode_e opc);
        ss_op_e res;
        case (opc)
            _DUP:    res = SS_DUP;
            _DROP:   res = SS_DROP;
            _OVER:   res = SS_OVER;
            _SWAP:   res = SS_SWAP;
            _ROT:    res = SS_ROT;
            _PICK:   res = SS_PICK;
            default: res = SS_NOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fs_dstack_if.sv
// Command/status bundle between the opcode sequencer (master) and the data
// stack (slave).
interface fs_dstack_if #(
    parameter int DSZ   = 32,
    parameter int DEPTH = 64
);
    localparam int CSZ = $clog2(DEPTH + 3);

    logic           op_valid;
    logic           op_ready;
    logic [3:0]     op;
    logic [DSZ-1:0] din;
    logic [DSZ-1:0] tos;
    logic [DSZ-1:0] nos;
    logic [CSZ-1:0] depth;
    logic           err;
    logic           ovf;
    logic           udf;

    modport master (
        output op_valid, op, din,
        input  op_ready, tos, nos, depth, err, ovf, udf
    );

    modport slave (
        input  op_valid, op, din,
        output op_ready, tos, nos, depth, err, ovf, udf
    );
endinterface

// File: rtl/fs_spram.sv
// Single-port synchronous-read RAM holding the stack cells below NOS.
// One-cycle read latency; a read in a write cycle returns the old contents.
module fs_spram #(
    parameter int DSZ   = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DSZ-1:0]           wdata,
    output logic [DSZ-1:0]           rdata
);
    logic [DSZ-1:0] mem_r [DEPTH];
    logic [DSZ-1:0] rdata_r;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/fs_dstack.sv
// ForthSuper data stack. TOS/NOS live in registers, deeper cells in fs_spram.
// Single-cycle commands complete in S_IDLE; commands needing a RAM cell issue
// the read on accept and consume it in S_RD.
// Build option: define FS_DSTACK_PICK_EN to enable SS_PICK; otherwise SS_PICK
// is rejected as an illegal command.
module fs_dstack
    import fs_dstack_pkg::*;
#(
    parameter int DSZ   = 32,
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    fs_dstack_if.slave bus
);
    localparam int ASZ = $clog2(DEPTH);
    localparam int CSZ = $clog2(DEPTH + 3);
    localparam logic [CSZ-1:0] FULL_DEPTH = CSZ'(DEPTH + 2);

    ss_state_e      state_r, state_s;
    ss_op_e         op_r, op_s, cmd_s;
    logic [DSZ-1:0] tos_r, tos_s, nos_r, nos_s, din_r, din_s;
    logic [CSZ-1:0] depth_r, depth_s;
    logic [ASZ-1:0] rd_addr_r, rd_addr_s;
    logic           use_ram_r, use_ram_s;
    logic           ready_r;
    logic           err_r, err_s, ovf_r, ovf_s, udf_r, udf_s;

    logic           ram_we_s;
    logic [ASZ-1:0] ram_addr_s, top_addr_s, spill_addr_s;
    logic [DSZ-1:0] ram_wdata_s, ram_rdata_s;

    assign cmd_s        = ss_op_e'(bus.op);
    // Deepest-but-two item (top RAM cell) and the slot NOS spills into.
    assign top_addr_s   = ASZ'(depth_r - CSZ'(3));
    assign spill_addr_s = ASZ'(depth_r - CSZ'(2));

`ifdef FS_DSTACK_PICK_EN
    logic           pick_ok_s;
    logic [ASZ-1:0] pick_addr_s;
    // Item n below TOS exists when n+2 <= depth; computed one bit wider so n cannot wrap.
    assign pick_ok_s   = (({1'b0, tos_r} + (DSZ + 1)'(2)) <= (DSZ + 1)'(depth_r));
    assign pick_addr_s = ASZ'(depth_r - CSZ'(2) - tos_r[CSZ-1:0]);
`endif

    fs_spram #(
        .DSZ   (DSZ),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, stack update, RAM port control and error flag logic.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        din_s       = din_r;
        tos_s       = tos_r;
        nos_s       = nos_r;
        depth_s     = depth_r;
        rd_addr_s   = rd_addr_r;
        use_ram_s   = use_ram_r;
        err_s       = 1'b0;
        ovf_s       = ovf_r;
        udf_s       = udf_r;
        ram_we_s    = 1'b0;
        ram_addr_s  = rd_addr_r;
        ram_wdata_s = nos_r;
        case (state_r)
            S_IDLE: begin
                if (bus.op_valid) begin
                    op_s       = cmd_s;
                    din_s      = bus.din;
                    rd_addr_s  = top_addr_s;
                    ram_addr_s = top_addr_s;
                    use_ram_s  = (depth_r >= CSZ'(3));
                    case (cmd_s)
                        SS_NOP: begin
                            state_s = S_IDLE;
                        end
                        SS_PUSH: begin
                            if (depth_r == FULL_DEPTH) begin
                                err_s = 1'b1;
                                ovf_s = 1'b1;
                            end else begin
                                tos_s      = bus.din;
                                nos_s      = tos_r;
                                depth_s    = depth_r + CSZ'(1);
                                ram_we_s   = (depth_r >= CSZ'(2));
                                ram_addr_s = spill_addr_s;
                            end
                        end
                        SS_DUP: begin
                            if (depth_r == FULL_DEPTH) begin
                                err_s = 1'b1;
                                ovf_s = 1'b1;
                            end else if (depth_r == CSZ'(0)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                nos_s      = tos_r;
                                depth_s    = depth_r + CSZ'(1);
                                ram_we_s   = (depth_r >= CSZ'(2));
                                ram_addr_s = spill_addr_s;
                            end
                        end
                        SS_OVER: begin
                            if (depth_r == FULL_DEPTH) begin
                                err_s = 1'b1;
                                ovf_s = 1'b1;
                            end else if (depth_r < CSZ'(2)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                tos_s      = nos_r;
                                nos_s      = tos_r;
                                depth_s    = depth_r + CSZ'(1);
                                ram_we_s   = 1'b1;
                                ram_addr_s = spill_addr_s;
                            end
                        end
                        SS_SWAP: begin
                            if (depth_r < CSZ'(2)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                tos_s = nos_r;
                                nos_s = tos_r;
                            end
                        end
                        SS_LOAD: begin
                            if (depth_r == CSZ'(0)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                tos_s = bus.din;
                            end
                        end
                        SS_POP, SS_DROP: begin
                            if (depth_r == CSZ'(0)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                state_s = S_RD;
                            end
                        end
                        SS_POP_LOAD: begin
                            if (depth_r < CSZ'(2)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                state_s = S_RD;
                            end
                        end
                        SS_ROT: begin
                            if (depth_r < CSZ'(3)) begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end else begin
                                state_s = S_RD;
                            end
                        end
`ifdef FS_DSTACK_PICK_EN
                        SS_PICK: begin
                            if (pick_ok_s) begin
                                state_s    = S_RD;
                                rd_addr_s  = pick_addr_s;
                                ram_addr_s = pick_addr_s;
                                use_ram_s  = (tos_r != {DSZ{1'b0}});
                            end else begin
                                err_s = 1'b1;
                                udf_s = 1'b1;
                            end
                        end
`else
                        SS_PICK: begin
                            err_s = 1'b1;
                            udf_s = 1'b1;
                        end
`endif
                        default: begin
                            err_s = 1'b1;
                            udf_s = 1'b1;
                        end
                    endcase
                end else begin
                    ram_addr_s = top_addr_s;
                end
            end
            S_RD: begin
                state_s = S_IDLE;
                case (op_r)
                    SS_POP, SS_DROP: begin
                        tos_s   = nos_r;
                        nos_s   = use_ram_r ? ram_rdata_s : {DSZ{1'b0}};
                        depth_s = depth_r - CSZ'(1);
                    end
                    SS_POP_LOAD: begin
                        tos_s   = din_r;
                        nos_s   = use_ram_r ? ram_rdata_s : {DSZ{1'b0}};
                        depth_s = depth_r - CSZ'(1);
                    end
                    SS_ROT: begin
                        // a b c -- b c a: old NOS (b) takes a's RAM slot.
                        tos_s    = ram_rdata_s;
                        nos_s    = tos_r;
                        ram_we_s = 1'b1;
                    end
`ifdef FS_DSTACK_PICK_EN
                    SS_PICK: begin
                        tos_s = use_ram_r ? ram_rdata_s : nos_r;
                    end
`endif
                    default: begin
                        state_s = S_IDLE;
                    end
                endcase
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            op_r      <= SS_NOP;
            din_r     <= {DSZ{1'b0}};
            tos_r     <= {DSZ{1'b0}};
            nos_r     <= {DSZ{1'b0}};
            depth_r   <= {CSZ{1'b0}};
            rd_addr_r <= {ASZ{1'b0}};
            use_ram_r <= 1'b0;
            ready_r   <= 1'b1;
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            op_r      <= op_s;
            din_r     <= din_s;
            tos_r     <= tos_s;
            nos_r     <= nos_s;
            depth_r   <= depth_s;
            rd_addr_r <= rd_addr_s;
            use_ram_r <= use_ram_s;
            ready_r   <= (state_s == S_IDLE);
            err_r     <= err_s;
            ovf_r     <= ovf_s;
            udf_r     <= udf_s;
        end
    end

    assign bus.op_ready = ready_r;
    assign bus.tos      = tos_r;
    assign bus.nos      = nos_r;
    assign bus.depth    = depth_r;
    assign bus.err      = err_r;
    assign bus.ovf      = ovf_r;
    assign bus.udf      = udf_r;
endmodule

// File: tb/tb_fs_dstack.sv
// Directed bench for fs_dstack: every command pushes its expected stack
// state to a scoreboard queue, which is popped and compared once the DUT
// returns to idle.
module tb_fs_dstack;
    import fs_dstack_pkg::*;

    localparam int DSZ   = 32;
    localparam int DEPTH = 8;
    localparam int FULL  = DEPTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fs_dstack_if #(.DSZ(DSZ), .DEPTH(DEPTH)) bus ();

    fs_dstack #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] tos;
        logic [31:0] nos;
        int          depth;
        logic        err;
        logic        ovf;
        logic        udf;
        int          busy;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int busy);
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "/tos"},   bus.tos, e.tos);
        check({e.tag, "/nos"},   bus.nos, e.nos);
        check({e.tag, "/depth"}, 32'(bus.depth), e.depth);
        check({e.tag, "/err"},   32'(bus.err), 32'(e.err));
        check({e.tag, "/ovf"},   32'(bus.ovf), 32'(e.ovf));
        check({e.tag, "/udf"},   32'(bus.udf), 32'(e.udf));
        check({e.tag, "/ready"}, 32'(bus.op_ready), 32'd1);
        check({e.tag, "/busy"},  busy, e.busy);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] din,
                          input logic [31:0] etos, input logic [31:0] enos, input int edep,
                          input logic eerr, input logic eovf, input logic eudf, input int ebusy);
        int busy = 0;
        sb_q.push_back('{tag, etos, enos, edep, eerr, eovf, eudf, ebusy});
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.din      = din;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        bus.din      = 32'd0;
        while (!bus.op_ready && busy < 8) begin
            busy++;
            @(negedge clk);
        end
        sample(busy);
    endtask

    task automatic do_reset(input string tag);
        sb_q.push_back('{tag, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 0});
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sample(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        bus.din      = 32'd0;

        do_reset("reset");

        // Underflow and illegal encodings on a nearly empty stack
        run_op("t3_drop_empty", SS_DROP, 32'd0, 32'd0, 32'd0, 0, 1'b1, 1'b0, 1'b1, 0);
        run_op("t3_push7",      SS_PUSH, 32'd7, 32'd7, 32'd0, 1, 1'b0, 1'b0, 1'b1, 0);
        run_op("t3_swap_d1",    SS_SWAP, 32'd0, 32'd7, 32'd0, 1, 1'b1, 1'b0, 1'b1, 0);
        run_op("illegal_op",    4'd13,   32'd0, 32'd7, 32'd0, 1, 1'b1, 1'b0, 1'b1, 0);

        // ROT and refill through RAM
        do_reset("reset_t1");
        run_op("t1_push1", SS_PUSH, 32'd1, 32'd1, 32'd0, 1, 1'b0, 1'b0, 1'b0, 0);
        run_op("t1_push2", SS_PUSH, 32'd2, 32'd2, 32'd1, 2, 1'b0, 1'b0, 1'b0, 0);
        run_op("t1_push3", SS_PUSH, 32'd3, 32'd3, 32'd2, 3, 1'b0, 1'b0, 1'b0, 0);
        run_op("t1_rot",   SS_ROT,  32'd0, 32'd1, 32'd3, 3, 1'b0, 1'b0, 1'b0, 1);
        run_op("t1_drop1", SS_DROP, 32'd0, 32'd3, 32'd2, 2, 1'b0, 1'b0, 1'b0, 1);
        run_op("t1_drop2", SS_DROP, 32'd0, 32'd2, 32'd0, 1, 1'b0, 1'b0, 1'b0, 1);

        // OVER / SWAP / DUP / LOAD with RAM spills read back by DROP
        do_reset("reset_ops");
        run_op("ops_push4", SS_PUSH, 32'd4, 32'd4, 32'd0, 1, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_push6", SS_PUSH, 32'd6, 32'd6, 32'd4, 2, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_push8", SS_PUSH, 32'd8, 32'd8, 32'd6, 3, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_over",  SS_OVER, 32'd0, 32'd6, 32'd8, 4, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_swap",  SS_SWAP, 32'd0, 32'd8, 32'd6, 4, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_dup",   SS_DUP,  32'd0, 32'd8, 32'd8, 5, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_load9", SS_LOAD, 32'd9, 32'd9, 32'd8, 5, 1'b0, 1'b0, 1'b0, 0);
        run_op("ops_drop1", SS_DROP, 32'd0, 32'd8, 32'd6, 4, 1'b0, 1'b0, 1'b0, 1);
        run_op("ops_drop2", SS_DROP, 32'd0, 32'd6, 32'd6, 3, 1'b0, 1'b0, 1'b0, 1);
        run_op("ops_drop3", SS_DROP, 32'd0, 32'd6, 32'd4, 2, 1'b0, 1'b0, 1'b0, 1);

        // POP_LOAD as ALU writeback
        do_reset("reset_t5");
        run_op("t5_push5",    SS_PUSH,     32'd5,  32'd5,  32'd0, 1, 1'b0, 1'b0, 1'b0, 0);
        run_op("t5_push7",    SS_PUSH,     32'd7,  32'd7,  32'd5, 2, 1'b0, 1'b0, 1'b0, 0);
        run_op("t5_pop_load", SS_POP_LOAD, 32'd12, 32'd12, 32'd0, 1, 1'b0, 1'b0, 1'b0, 1);

        // PICK
        do_reset("reset_t4");
        run_op("t4_push10", SS_PUSH, 32'd10, 32'd10, 32'd0,  1, 1'b0, 1'b0, 1'b0, 0);
        run_op("t4_push20", SS_PUSH, 32'd20, 32'd20, 32'd10, 2, 1'b0, 1'b0, 1'b0, 0);
        run_op("t4_push30", SS_PUSH, 32'd30, 32'd30, 32'd20, 3, 1'b0, 1'b0, 1'b0, 0);
        run_op("t4_push40", SS_PUSH, 32'd40, 32'd40, 32'd30, 4, 1'b0, 1'b0, 1'b0, 0);
        run_op("t4_push2",  SS_PUSH, 32'd2,  32'd2,  32'd40, 5, 1'b0, 1'b0, 1'b0, 0);
`ifdef FS_DSTACK_PICK_EN
        run_op("t4_pick",   SS_PICK, 32'd0,  32'd20, 32'd40, 5, 1'b0, 1'b0, 1'b0, 1);
`else
        run_op("t4_pick",   SS_PICK, 32'd0,  32'd2,  32'd40, 5, 1'b1, 1'b0, 1'b1, 0);
`endif

        // Fill to capacity, overflow, then LIFO drain
        do_reset("reset_t2");
        for (int i = 1; i <= FULL; i++) begin
            run_op($sformatf("t2_push%0d", i), SS_PUSH, 32'(100 + i), 32'(100 + i),
                   (i > 1) ? 32'(99 + i) : 32'd0, i, 1'b0, 1'b0, 1'b0, 0);
        end
        run_op("t2_push_ovf", SS_PUSH, 32'd99, 32'(100 + FULL), 32'(99 + FULL), FULL,
               1'b1, 1'b1, 1'b0, 0);
        run_op("t2_dup_ovf",  SS_DUP,  32'd0,  32'(100 + FULL), 32'(99 + FULL), FULL,
               1'b1, 1'b1, 1'b0, 0);
        for (int k = 1; k < FULL; k++) begin
            run_op($sformatf("t2_drop%0d", k), SS_DROP, 32'd0, 32'(100 + FULL - k),
                   ((FULL - k) >= 2) ? 32'(99 + FULL - k) : 32'd0, FULL - k,
                   1'b0, 1'b1, 1'b0, 1);
        end

        // Reset while a DROP is in its read cycle
        do_reset("reset_t6");
        run_op("t6_push1", SS_PUSH, 32'd1, 32'd1, 32'd0, 1, 1'b0, 1'b0, 1'b0, 0);
        run_op("t6_push2", SS_PUSH, 32'd2, 32'd2, 32'd1, 2, 1'b0, 1'b0, 1'b0, 0);
        run_op("t6_push3", SS_PUSH, 32'd3, 32'd3, 32'd2, 3, 1'b0, 1'b0, 1'b0, 0);
        run_op("t6_push4", SS_PUSH, 32'd4, 32'd4, 32'd3, 4, 1'b0, 1'b0, 1'b0, 0);
        sb_q.push_back('{"t6_rst_in_rd", 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 0});
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = SS_DROP;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        check("t6_busy_in_rd", 32'(bus.op_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
